// File: rtl/spi_tx_char_packer_pkg.sv
// ---------------------------------------------------------------------------
// spi_tx_char_packer_pkg
// Shared definitions for the eSPI transmit character packer:
//   - TX_FIFO_DEPTH      : default word-FIFO depth (32-bit words)
//   - CHAR_LEN_HALF_MIN  : CSMODE LEN values at or above this select 16-bit chars
//   - char_mode_e        : CHAR_MODE_BYTE / CHAR_MODE_HALF
//   - pk_state_e         : unpacker states
//   - char_of/last_lane  : lane extraction helpers
// ---------------------------------------------------------------------------
package spi_tx_char_packer_pkg;

    localparam int         TX_FIFO_DEPTH     = 8;
    localparam logic [3:0] CHAR_LEN_HALF_MIN = 4'd8;

    typedef enum logic {
        CHAR_MODE_BYTE = 1'b0,
        CHAR_MODE_HALF = 1'b1
    } char_mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } pk_state_e;

    // Character for a given lane of a word, zero-extended to 16 bits.
    // Lane 0 is the least-significant lane.
    function automatic logic [15:0] char_of(input logic [31:0] word,
                                            input char_mode_e  mode,
                                            input logic [1:0]  lane);
        logic [15:0] c;
        c = 16'h0000;
        if (mode == CHAR_MODE_HALF) begin
            c = lane[0] ? word[31:16] : word[15:0];
        end else begin
            case (lane)
                2'd0:    c = {8'h00, word[7:0]};
                2'd1:    c = {8'h00, word[15:8]};
                2'd2:    c = {8'h00, word[23:16]};
                default: c = {8'h00, word[31:24]};
            endcase
        end
        return c;
    endfunction

    function automatic logic last_lane(input char_mode_e mode, input logic [1:0] lane);
        return (mode == CHAR_MODE_HALF) ? (lane == 2'd1) : (lane == 2'd3);
    endfunction

endpackage

// File: rtl/spi_tx_char_packer_if.sv
// ---------------------------------------------------------------------------
// spi_tx_char_packer_if
// Bundles the register-side write port, the control/status signals and the
// character handshake toward the shift engine.
//   master : register block / shift engine side (drives controls, writes, READY)
//   slave  : the packer (drives WERR, CHAR, CHAR_VALID, TNF, TXE, TXCNT)
// ---------------------------------------------------------------------------
interface spi_tx_char_packer_if #(
    parameter int AW = 3
);
    import spi_tx_char_packer_pkg::*;

    logic          S_ENABLE;
    logic          S_FLUSH;
    logic [3:0]    S_CHAR_LEN;
    logic [31:0]   S_WDATA;
    logic          S_WVALID;
    logic          S_WERR;
    logic [15:0]   S_CHAR;
    logic          S_CHAR_VALID;
    logic          S_CHAR_READY;
    logic          S_TNF;
    logic          S_TXE;
    logic [AW:0]   S_TXCNT;

    modport master (
        output S_ENABLE, S_FLUSH, S_CHAR_LEN, S_WDATA, S_WVALID, S_CHAR_READY,
        input  S_WERR, S_CHAR, S_CHAR_VALID, S_TNF, S_TXE, S_TXCNT
    );

    modport slave (
        input  S_ENABLE, S_FLUSH, S_CHAR_LEN, S_WDATA, S_WVALID, S_CHAR_READY,
        output S_WERR, S_CHAR, S_CHAR_VALID, S_TNF, S_TXE, S_TXCNT
    );

endinterface

// File: rtl/spi_word_fifo.sv
// ---------------------------------------------------------------------------
// spi_word_fifo
// Synchronous 32-bit word FIFO with registered occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over push/pop
//   push/wdata : write (ignored when full)
//   pop        : advance read pointer (ignored when empty)
//   rdata      : word at the read pointer (show-ahead, valid when !empty)
//   count/full/empty : occupancy status from registered state
// ---------------------------------------------------------------------------
module spi_word_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [31:0]   wdata,
    input  logic          pop,
    output logic [31:0]   rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [31:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // Show-ahead read: the packer loads the head word in the same edge it pops.
    assign rdata   = mem[rptr_q];
    assign push_ok = push && !full && !clr;
    assign pop_ok  = pop && !empty && !clr;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Pointers are AW bits wide, so wrap modulo DEPTH happens naturally.
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok)  rptr_d = rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/spi_tx_char_packer.sv
// ---------------------------------------------------------------------------
// spi_tx_char_packer
// Buffers SPITF words and unpacks them into 8- or 16-bit characters, LSB lane
// first, for the character shift engine.
//   S_SYSCLK, S_RESETN : clock, asynchronous active-low reset
//   bus (slave)        : ENABLE/FLUSH/CHAR_LEN controls, WDATA/WVALID writes,
//                        WERR drop pulse, CHAR/CHAR_VALID/CHAR_READY handshake,
//                        TNF/TXE/TXCNT status
// ---------------------------------------------------------------------------
module spi_tx_char_packer
    import spi_tx_char_packer_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH,
    parameter int AW    = 3
) (
    input  logic                 S_SYSCLK,
    input  logic                 S_RESETN,
    spi_tx_char_packer_if.slave  bus
);
    logic         clr;
    logic         fifo_push;
    logic         fifo_pop;
    logic [31:0]  fifo_rdata;
    logic [AW:0]  fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         load;

    pk_state_e    state_q, state_d;
    char_mode_e   mode_q,  mode_d;
    logic [31:0]  word_q,  word_d;
    logic [1:0]   lane_q,  lane_d;
    logic [15:0]  char_q,  char_d;
    logic         valid_q, valid_d;
    logic         werr_q,  werr_d;

    assign clr       = !bus.S_ENABLE || bus.S_FLUSH;
    assign fifo_push = bus.S_WVALID && !fifo_full && !clr;

    spi_word_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (S_SYSCLK),
        .rst_n (S_RESETN),
        .clr   (clr),
        .push  (fifo_push),
        .wdata (bus.S_WDATA),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        word_d   = word_q;
        lane_d   = lane_q;
        char_d   = char_q;
        valid_d  = valid_q;
        // Full is judged on the registered count, so a same-cycle pop
        // does not rescue a write into a full FIFO.
        werr_d   = bus.S_WVALID && fifo_full;
        load     = 1'b0;
        fifo_pop = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (!fifo_empty) load = 1'b1;
            end
            default: begin
                if (bus.S_CHAR_READY) begin
                    if (last_lane(mode_q, lane_q)) begin
                        // Back-to-back reload keeps the character stream gap-free.
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            state_d = ST_EMPTY;
                        end
                    end else begin
                        lane_d = lane_q + 2'd1;
                        char_d = char_of(word_q, mode_q, lane_q + 2'd1);
                    end
                end
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            word_d   = fifo_rdata;
            // Char width is frozen per word; LEN changes apply from the next word.
            mode_d   = (bus.S_CHAR_LEN >= CHAR_LEN_HALF_MIN) ? CHAR_MODE_HALF : CHAR_MODE_BYTE;
            lane_d   = 2'd0;
            char_d   = char_of(fifo_rdata, mode_d, 2'd0);
            valid_d  = 1'b1;
            state_d  = ST_SHIFT;
        end

        if (clr) begin
            state_d  = ST_EMPTY;
            mode_d   = CHAR_MODE_BYTE;
            word_d   = '0;
            lane_d   = '0;
            char_d   = '0;
            valid_d  = 1'b0;
            werr_d   = 1'b0;
            fifo_pop = 1'b0;
        end
    end

    always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
        if (!S_RESETN) begin
            state_q <= ST_EMPTY;
            mode_q  <= CHAR_MODE_BYTE;
            word_q  <= '0;
            lane_q  <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            werr_q  <= werr_d;
        end
    end

    assign bus.S_CHAR       = char_q;
    assign bus.S_CHAR_VALID = valid_q;
    assign bus.S_WERR       = werr_q;
    assign bus.S_TNF        = !fifo_full;
    assign bus.S_TXE        = fifo_empty && (state_q == ST_EMPTY);
    assign bus.S_TXCNT      = fifo_count;

endmodule

// File: doc/spi_tx_char_packer.md
Name: spi_tx_char_packer

Overview:
- Transmit-side stage between the eSPI register interface (SPITF writes) and the character shift engine.
- Buffers 32-bit SPITF words in a word FIFO.
- Unpacks each word into characters of 8 or 16 bits, least-significant lane first.
- Presents characters to the shift engine over a valid/ready handshake and drives the TNF/TXE status used for SPIE/SPIM interrupts.

Parameters:
- DEPTH, 8, FIFO depth in 32-bit words; power of 2, minimum 2.
- AW, 3, log2(DEPTH); FIFO pointer width.

Ports:
- S_SYSCLK  input  1  platform clock
- S_RESETN  input  1  asynchronous active-low reset
- S_ENABLE  input  1  SPMODE[EN]; low clears FIFO and unpacker
- S_FLUSH  input  1  one-cycle pulse; clears FIFO and unpacker
- S_CHAR_LEN  input  4  CSMODE LEN field; <=7 selects byte chars, >=8 selects halfword chars
- S_WDATA  input  32  SPITF write data
- S_WVALID  input  1  one-cycle SPITF write strobe
- S_WERR  output  1  one-cycle pulse: write dropped because FIFO full
- S_CHAR  output  16  character to shift engine, zero-extended
- S_CHAR_VALID  output  1  S_CHAR is valid
- S_CHAR_READY  input  1  shift engine consumes S_CHAR
- S_TNF  output  1  FIFO not full (count < DEPTH)
- S_TXE  output  1  FIFO empty and unpacker empty
- S_TXCNT  output  AW+1  words currently in FIFO

Behaviour:
- Reset (S_RESETN low, asynchronous) values: pointers 0; count 0; S_CHAR_VALID 0; S_CHAR 0; S_WERR 0; S_TNF 1; S_TXE 1; S_TXCNT 0.
- Clear (S_ENABLE low or S_FLUSH high at an edge) produces the same state as reset, synchronously. Clear has priority over push and pop in the same cycle.
- Push: at an edge with S_WVALID=1, S_ENABLE=1, S_FLUSH=0 and count<DEPTH, S_WDATA is written at wptr; wptr and count increment.
- Full: push with count==DEPTH (registered value) is dropped and S_WERR pulses for 1 cycle. This holds even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH.
- Unpacker has two states:
  - EMPTY: if count>0, load the word at rptr into the holding register, pop (rptr+1, count-1), and latch the char mode from S_CHAR_LEN (0 = byte, 1 = halfword). Set lane=0, S_CHAR_VALID=1 and S_CHAR to lane 0, all at the same edge. Go to SHIFT.
  - SHIFT: S_CHAR_VALID held high and S_CHAR stable until S_CHAR_READY. On a handshake edge:
    - Byte mode: lane+1 (lanes 0..3, S_CHAR = {8'h0, word[8*lane+7:8*lane]}).
    - Halfword mode: lane+1 (lanes 0..1, S_CHAR = word[16*lane+15:16*lane]).
    - After the last lane: if count>0, load the next word in the same edge (back-to-back, no bubble). Otherwise S_CHAR_VALID=0 and go to EMPTY.
- Push and pop in the same cycle: count unchanged; both take effect.
- Latency: a word written at edge k into an empty block gives S_CHAR_VALID=1 after edge k+1.
- Char mode is sampled only at word load. A change to S_CHAR_LEN mid-word takes effect at the next word.
- S_TNF = (count<DEPTH); S_TXE = (count==0) and state EMPTY; S_TXCNT = count. All are registered-state derived, with no combinational path from S_WVALID.
- S_CHAR_READY while S_CHAR_VALID=0 is ignored.

Decomposition:
- Add to the shared register bit-definition include: CHAR_MODE_BYTE/CHAR_MODE_HALF localparams, the LEN threshold (8), and the TX FIFO depth default.
- One sub-module: spi_word_fifo, a synchronous FIFO with registered count, flush input and full/empty outputs. The packer owns the lane counter and handshake.

Test Plan:
- Reset/idle: after S_RESETN deassert -> S_TNF=1, S_TXE=1, S_CHAR_VALID=0, S_TXCNT=0.
- Byte mode, LEN=7, write 32'h0403_0201, READY tied high -> chars 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles; first VALID one cycle after write; then S_TXE=1.
- Halfword mode, LEN=15, write 32'h1122_3344 then 32'h5566_7788 -> chars 0x3344, 0x1122, 0x7788, 0x5566 with no bubble between words.
- Full: READY=0, write 9 words with DEPTH=8 -> one word loaded into the unpacker, so 8 remain in the FIFO and the 9th is accepted. 10th write -> S_WERR pulse, S_TNF=0, S_TXCNT=8, 10th word never emitted.
- Backpressure: READY toggled 0/1 every cycle -> S_CHAR stable while VALID&&!READY; no char lost or duplicated.
- Flush/enable mid-word: after char 0x0001 is consumed, pulse S_FLUSH (then separately drop S_ENABLE) -> next cycle S_CHAR_VALID=0, S_TXE=1, S_TXCNT=0. A subsequent write 32'h0000_00AA emits 0x00AA first.
